uart_rx_param: RTL

Parametrised UART receiver for the FPGA serial link: configurable data width, stop-bit count and optional parity. It adds per-frame framing, parity and break status, and recovers cleanly from noise, breaks and mid-frame reset. It sits between the FPGA pin synchroniser and the command decoder, delivering one word per valid-strobe.

---
 rtl/uart_rx_param_if.sv | 23 ++
 rtl/uart_rx_param.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param_if.sv
// Serial line and word/status bundle for uart_rx_param.
// The receiver uses the master side; the consumer or a bench uses the slave side.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Rx_Serial;
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Data;
  logic                 o_Frame_Err;
  logic                 o_Parity_Err;
  logic                 o_Break;
  logic                 o_Busy;

  modport master (
    input  i_Rx_Serial,
    output o_Rx_DV, o_Rx_Data, o_Frame_Err, o_Parity_Err, o_Break, o_Busy
  );

  modport slave (
    output i_Rx_Serial,
    input  o_Rx_DV, o_Rx_Data, o_Frame_Err, o_Parity_Err, o_Break, o_Busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with framing, parity and break status.
// Define UART_RX_PARITY_EN to compile in the parity bit and checker.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  uart_rx_param_if.master rx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] TOP       = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`else
  localparam logic PAR_EN = 1'b0;
  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP, DONE} state_t;
`endif

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p ^ ODD;
  endfunction

  state_t               state, state_n;
  logic                 sync1, sync2;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 fe_acc, fe_acc_n, one_seen, one_seen_n, par_bit, par_bit_n;
  logic                 dv, dv_n, fe, fe_n, pe, pe_n, brk, brk_n, busy, busy_n;
  logic [DATA_BITS-1:0] data, data_n;

  // Next-state, counters, sampling and output-register updates.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shreg_n    = shreg;
    fe_acc_n   = fe_acc;
    one_seen_n = one_seen;
    par_bit_n  = par_bit;
    dv_n       = 1'b0;
    data_n     = data;
    fe_n       = fe;
    pe_n       = pe;
    brk_n      = brk;
    case (state)
      WAIT_HIGH: begin
        if (sync2) state_n = IDLE;
        else       state_n = WAIT_HIGH;
      end
      IDLE: begin
        cnt_n      = '0;
        idx_n      = '0;
        shreg_n    = '0;
        fe_acc_n   = 1'b0;
        one_seen_n = 1'b0;
        par_bit_n  = 1'b0;
        if (!sync2) state_n = START;
        else        state_n = IDLE;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n = '0;
          if (sync2) state_n = IDLE;
          else       state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == TOP) begin
          cnt_n      = '0;
          shreg_n    = {sync2, shreg[DATA_BITS-1:1]};
          one_seen_n = one_seen | sync2;
          if (idx == LAST_DATA) begin
            idx_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == TOP) begin
          cnt_n      = '0;
          par_bit_n  = sync2;
          one_seen_n = one_seen | sync2;
          state_n    = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == TOP) begin
          cnt_n      = '0;
          fe_acc_n   = fe_acc | ~sync2;
          one_seen_n = one_seen | sync2;
          if (idx == LAST_STOP) begin
            // Deliver the word with its flags, whatever they say.
            state_n = DONE;
            dv_n    = 1'b1;
            data_n  = shreg;
            fe_n    = fe_acc | ~sync2;
            pe_n    = PAR_EN & parity_mismatch(shreg, par_bit);
            brk_n   = ~(one_seen | sync2);
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        if (fe_acc) state_n = WAIT_HIGH;
        else        state_n = IDLE;
      end
      default: state_n = WAIT_HIGH;
    endcase
    busy_n = (state_n != IDLE);
  end

  // Synchroniser, FSM state and registered outputs; reset wins over everything.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      state    <= WAIT_HIGH;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      fe_acc   <= 1'b0;
      one_seen <= 1'b0;
      par_bit  <= 1'b0;
      dv       <= 1'b0;
      data     <= '0;
      fe       <= 1'b0;
      pe       <= 1'b0;
      brk      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sync1    <= rx.i_Rx_Serial;
      sync2    <= sync1;
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      fe_acc   <= fe_acc_n;
      one_seen <= one_seen_n;
      par_bit  <= par_bit_n;
      dv       <= dv_n;
      data     <= data_n;
      fe       <= fe_n;
      pe       <= pe_n;
      brk      <= brk_n;
      busy     <= busy_n;
    end
  end

  assign rx.o_Rx_DV      = dv;
  assign rx.o_Rx_Data    = data;
  assign rx.o_Frame_Err  = fe;
  assign rx.o_Parity_Err = pe;
  assign rx.o_Break      = brk;
  assign rx.o_Busy       = busy;
endmodule
